// File: rtl/cam_capture_pkg.sv
// Shared types and defaults for the camera frame-capture stage.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } cap_state_e;

  typedef logic [15:0] rgb565_t;

  localparam int DEF_OUT_W = 40;
  localparam int DEF_OUT_H = 30;
  localparam int DEF_DECIM = 16;
  localparam int CNT_W     = 10;

endpackage

// File: rtl/cam_pixel_assembler.sv
// Pairs incoming camera bytes into RGB565 pixels and tracks input column/row position.
module cam_pixel_assembler
  import cam_capture_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             href_i,
  input  logic [7:0]       dat_i,
  output logic             pix_valid_o,
  output logic [15:0]      pix_data_o,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             phase_q, phase_d;
  logic             href_q;
  logic [7:0]       hi_q, hi_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;

  always_comb begin
    phase_d = 1'b0;
    hi_d    = hi_q;
    col_d   = col_q;
    row_d   = row_q;
    if (!en_i) begin
      col_d = '0;
      row_d = '0;
    end else if (href_i) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hi_d = dat_i;
      end else if (col_q != CNT_MAX) begin
        col_d = col_q + 1'b1;
      end
    end else if (href_q) begin
      // Line end: any unpaired trailing byte is simply abandoned with the phase reset.
      col_d = '0;
      if (row_q != CNT_MAX) row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      href_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      phase_q <= phase_d;
      href_q  <= href_i;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_ff @(posedge clk) begin
    hi_q <= hi_d;
  end

  // The pixel is reported combinationally on its low byte, tagged with its pre-increment column.
  assign pix_valid_o = en_i & href_i & phase_q;
  assign pix_data_o  = {hi_q, dat_i};
  assign col_o       = col_q;
  assign row_o       = row_q;

endmodule

// File: rtl/cam_frame_capture.sv
// One-shot frame capture: arms on start, decimates and crops one frame, streams pixels to the scratchpad.
module cam_frame_capture
  import cam_capture_pkg::*;
#(
  parameter int OUT_W      = DEF_OUT_W,
  parameter int OUT_H      = DEF_OUT_H,
  parameter int DECIM      = DEF_DECIM,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [7:0]            cam_dat,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data
);

  localparam int                    SH      = $clog2(DECIM);
  localparam logic [CNT_W-1:0]      DMASK   = CNT_W'(DECIM - 1);
  localparam logic [CNT_W-1:0]      OUT_W_C = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0]      OUT_H_C = CNT_W'(OUT_H);
  localparam logic [ADDR_WIDTH-1:0] OUT_W_A = ADDR_WIDTH'(OUT_W);

  cap_state_e state_q, state_d;
  logic       vsync_q;
  logic       overflow_q;
  logic       wr_valid_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [15:0]           wr_data_q;

  logic                  pix_valid;
  logic [15:0]           pix_data;
  logic [CNT_W-1:0]      col_in, row_in, col_out, row_out;
  logic                  keep;
  logic [ADDR_WIDTH-1:0] pix_addr;

  cam_pixel_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .en_i        (state_q == CAPTURE),
    .href_i      (cam_href),
    .dat_i       (cam_dat),
    .pix_valid_o (pix_valid),
    .pix_data_o  (pix_data),
    .col_o       (col_in),
    .row_o       (row_in)
  );

  assign col_out  = col_in >> SH;
  assign row_out  = row_in >> SH;
  assign keep     = pix_valid && ((col_in & DMASK) == '0) && ((row_in & DMASK) == '0)
                    && (col_out < OUT_W_C) && (row_out < OUT_H_C);
  // Address is derived from position, so dropped or short lines never shift later pixels.
  assign pix_addr = ADDR_WIDTH'(row_out) * OUT_W_A + ADDR_WIDTH'(col_out);

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM: begin
        busy = 1'b1;
        if (vsync_q && !cam_vsync) state_d = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        // vsync was low on entry, so a high level here means it has risen; drain the pending write first.
        if (cam_vsync && !wr_valid_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q    <= 1'b0;
      overflow_q <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      vsync_q <= cam_vsync;
      if (state_q == IDLE && start) overflow_q <= 1'b0;
      if (keep) begin
        if (wr_valid_q && !wr_ready) begin
          overflow_q <= 1'b1;
        end else begin
          wr_valid_q <= 1'b1;
          wr_addr_q  <= pix_addr;
          wr_data_q  <= pix_data;
        end
      end else if (wr_ready) begin
        wr_valid_q <= 1'b0;
      end
    end
  end

  assign overflow = overflow_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Randomized frame bench for cam_frame_capture against a per-address scoreboard of expected pixels.
module tb_cam_frame_capture;

  localparam int OUT_W = 4;
  localparam int OUT_H = 3;
  localparam int DECIM = 2;
  localparam int AW    = 4;
  localparam int NADDR = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, cam_vsync, cam_href, start, wr_ready;
  logic [7:0]    cam_dat;
  logic          busy, done, overflow, wr_valid;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  cam_frame_capture #(.OUT_W(OUT_W), .OUT_H(OUT_H), .DECIM(DECIM), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_dat(cam_dat),
    .start(start), .busy(busy), .done(done), .overflow(overflow), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame description and expected image.
  int          n_lines;
  int          line_nb  [8];
  logic [7:0]  line_dat [8][24];
  logic [15:0] exp_mem  [NADDR];
  bit          exp_kept [NADDR];
  bit          wrote    [NADDR];
  int          last_addr;
  int          acc_cnt  = 0;
  int          done_cnt = 0;
  bit          bp_mode  = 1'b0;
  bit          lat_pend = 1'b0;
  int          lat_addr;
  bit          hold_prev = 1'b0;
  logic [20:0] prev_word;

  function automatic bit is_kept(int r, int p);
    return (r % DECIM == 0) && (p % DECIM == 0) && (r / DECIM < OUT_H) && (p / DECIM < OUT_W);
  endfunction

  task automatic build_model();
    for (int a = 0; a < NADDR; a++) begin
      exp_kept[a] = 1'b0;
      wrote[a]    = 1'b0;
      exp_mem[a]  = 16'h0;
    end
    for (int r = 0; r < n_lines; r++)
      for (int p = 0; p < line_nb[r] / 2; p++)
        if (is_kept(r, p)) begin
          exp_kept[(r / DECIM) * OUT_W + p / DECIM] = 1'b1;
          exp_mem[(r / DECIM) * OUT_W + p / DECIM]  = {line_dat[r][2*p], line_dat[r][2*p+1]};
        end
    last_addr = -1;
  endtask

  task automatic gen_seq(input int nl, input int nb);
    n_lines = nl;
    for (int r = 0; r < nl; r++) begin
      line_nb[r] = nb;
      for (int b = 0; b < 24; b++) line_dat[r][b] = 8'((r * 16 + b) & 8'hff);
    end
  endtask

  task automatic gen_random(input int min_lines);
    n_lines = $urandom_range(min_lines, 8);
    for (int r = 0; r < n_lines; r++) begin
      line_nb[r] = $urandom_range(1, 22);
      for (int b = 0; b < 24; b++) line_dat[r][b] = 8'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("hold_stable", 32'({wr_valid, wr_addr, wr_data}), 32'(prev_word));
      if (done) begin
        done_cnt++;
        chk("done_with_pending_write", 32'(wr_valid), 32'd0);
      end
      if (wr_valid && wr_ready) begin
        chk("wr_in_window", 32'(exp_kept[wr_addr]), 32'd1);
        chk("wr_data", 32'(wr_data), 32'(exp_mem[wr_addr]));
        chk("wr_addr_order", 32'(int'(wr_addr) > last_addr), 32'd1);
        last_addr      = int'(wr_addr);
        wrote[wr_addr] = 1'b1;
        acc_cnt++;
      end
      hold_prev = wr_valid && !wr_ready;
      prev_word = {wr_valid, wr_addr, wr_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (lat_pend) begin
      chk("latency_valid", 32'(wr_valid), 32'd1);
      chk("latency_addr", 32'(wr_addr), 32'(lat_addr));
      lat_pend = 1'b0;
    end
    wr_ready = bp_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
  endtask

  task automatic drive_frame(input bit do_start, input bit start_mid, input bit abort);
    int d0, a0, guard, miss;
    bit aborted;
    build_model();
    d0 = done_cnt;
    a0 = acc_cnt;
    aborted = 1'b0;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    repeat (3) tick();
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_on_start", 32'(busy), 32'd1);
      chk("overflow_clear_on_start", 32'(overflow), 32'd0);
    end
    repeat (2) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
    for (int r = 0; r < n_lines; r++) begin
      for (int b = 0; b < line_nb[r]; b++) begin
        if (abort && !aborted && (acc_cnt - a0) >= 3) begin
          reset    = 1'b1;
          lat_pend = 1'b0;
          tick();
          reset   = 1'b0;
          aborted = 1'b1;
          chk("reset_wr_valid", 32'(wr_valid), 32'd0);
          chk("reset_busy", 32'(busy), 32'd0);
        end
        cam_href = 1'b1;
        cam_dat  = line_dat[r][b];
        start    = start_mid && r == 1 && b == 0;
        if (b % 2 == 1 && !bp_mode && !aborted && is_kept(r, b / 2)) begin
          lat_pend = 1'b1;
          lat_addr = (r / DECIM) * OUT_W + (b / 2) / DECIM;
        end
        tick();
        if (start) chk("busy_after_ignored_start", 32'(busy), 32'd1);
      end
      cam_href = 1'b0;
      start    = 1'b0;
      repeat ($urandom_range(2, 4)) tick();
    end
    cam_vsync = 1'b1;
    if (aborted) begin
      repeat (20) tick();
      chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
    end else begin
      guard = 0;
      while (done_cnt == d0 && guard < 400) begin
        tick();
        guard++;
      end
      repeat (3) tick();
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("busy_after_done", 32'(busy), 32'd0);
      miss = 0;
      for (int a = 0; a < NADDR; a++) if (exp_kept[a] && !wrote[a]) miss++;
      chk("overflow_flag", 32'(overflow), 32'(miss != 0));
      if (!bp_mode) chk("missing_writes", 32'(miss), 32'd0);
    end
  endtask

  initial begin
    int a0;
    reset = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_dat = 8'h0;
    start = 1'b0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_wr_valid", 32'(wr_valid), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    reset = 1'b0;
    tick();

    // Nominal sequential-byte frame, then a one-line short frame, then odd-length lines.
    gen_seq(6, 16);
    drive_frame(1'b1, 1'b0, 1'b0);
    gen_seq(1, 16);
    drive_frame(1'b1, 1'b0, 1'b0);
    gen_seq(3, 16);
    line_nb[1] = 2;
    line_nb[2] = 7;
    drive_frame(1'b1, 1'b0, 1'b0);

    // Start in mid-capture must not restart the frame.
    gen_random(2);
    drive_frame(1'b1, 1'b1, 1'b0);

    // Arm while vsync is already low: nothing may be written until a full blanking period.
    n_lines = 0;
    build_model();
    a0 = acc_cnt;
    cam_vsync = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_armed", 32'(busy), 32'd1);
    for (int l = 0; l < 2; l++) begin
      for (int b = 0; b < 10; b++) begin
        cam_href = 1'b1;
        cam_dat  = 8'($urandom);
        tick();
      end
      cam_href = 1'b0;
      repeat (3) tick();
    end
    chk("arm_no_early_writes", 32'(acc_cnt - a0), 32'd0);
    gen_random(1);
    drive_frame(1'b0, 1'b0, 1'b0);

    // Heavy backpressure, then a clean frame that must clear the sticky overflow.
    bp_mode = 1'b1;
    for (int f = 0; f < 4; f++) begin
      gen_random(1);
      drive_frame(1'b1, 1'b0, 1'b0);
    end
    bp_mode = 1'b0;
    gen_seq(6, 16);
    drive_frame(1'b1, 1'b0, 1'b0);

    // Reset mid-capture, then a fresh capture starting from address 0.
    gen_seq(6, 16);
    drive_frame(1'b1, 1'b0, 1'b1);
    gen_seq(6, 16);
    drive_frame(1'b1, 1'b0, 1'b0);

    for (int f = 0; f < 8; f++) begin
      bp_mode = f[0];
      gen_random(1);
      drive_frame(1'b1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, observed no end expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cam_frame_capture.md
Name: cam_frame_capture

Overview:
- Pixel-clock-domain capture stage directly downstream of the camera input registers.
- Consumes registered cam_dat/cam_href/cam_vsync; assembles RGB565 byte pairs into 16-bit pixels.
- Decimates by DECIM in both axes, crops to OUT_W x OUT_H, streams pixels with linear addresses to the scratchpad write port.
- Armed by a one-shot start; captures exactly one frame, then reports done.

Parameters:
- OUT_W, 40, output pixels per line.
- OUT_H, 30, output lines per frame.
- DECIM, 16, keep 1 of every DECIM pixels and lines (power of two, 1..64).
- ADDR_WIDTH, 11, width of wr_addr; must satisfy 2**ADDR_WIDTH >= OUT_W*OUT_H.

Ports:
- clk  in  1  pixel clock (cam_xclk domain); all state on rising edge.
- reset  in  1  synchronous, active-high.
- cam_vsync  in  1  registered vsync; high = vertical blanking.
- cam_href  in  1  registered line-valid.
- cam_dat  in  8  registered pixel byte.
- start  in  1  one-cycle pulse; arms a capture.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of captured frame.
- overflow  out  1  sticky; a pixel was dropped due to backpressure.
- wr_valid  out  1  pixel write request.
- wr_ready  in  1  sink accepts when wr_valid & wr_ready.
- wr_addr  out  ADDR_WIDTH  linear address = out_row*OUT_W + out_col.
- wr_data  out  16  RGB565 pixel, first byte in [15:8].

Behaviour:
- Reset: state IDLE. busy=0, done=0, overflow=0, wr_valid=0, wr_addr=0, wr_data=0. All counters cleared. Reset mid-frame abandons the capture with no done pulse.
- States:
  - IDLE: start -> ARM; busy=1; overflow cleared.
  - ARM: wait for cam_vsync 1->0 transition (detected vs. 1-cycle delayed copy) -> CAPTURE. A vsync already low when entering ARM does not count; a full blanking period is required.
  - CAPTURE: cam_vsync 0->1 -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- start outside IDLE is ignored.
- Byte phase (CAPTURE only):
  - Toggles every cycle cam_href=1; cleared when cam_href=0.
  - Phase 0 latches cam_dat as the high byte.
  - Phase 1 completes a pixel and increments col_in (10 bits, saturating).
  - A trailing odd byte at href fall is discarded.
- Line counting: on cam_href 1->0, row_in increments (saturating) and col_in clears.
- Keep rule: col_in%DECIM==0, row_in%DECIM==0, col_in/DECIM<OUT_W, row_in/DECIM<OUT_H. Pixels outside this window are silently ignored.
- Write output:
  - A kept pixel loads wr_data/wr_addr and asserts wr_valid on the cycle after the phase-1 byte (latency 1).
  - wr_valid holds with stable data/addr until wr_ready.
  - The address counter increments per kept pixel, whether written or dropped, so addresses stay position-exact.
- Backpressure:
  - A new kept pixel arriving while wr_valid & !wr_ready is dropped; overflow set (sticky until next start).
  - Kept pixel on the same cycle the current one is accepted: the new pixel is loaded, with no gap.
- Frame end: the pending write, if any, completes before DONE. CAPTURE waits in place on vsync rise until wr_valid=0, then moves to DONE.
- Short frame (fewer lines than OUT_H*DECIM): done still pulses at vsync rise; unwritten addresses untouched.

Decomposition:
- Package cam_capture_pkg: state enum (IDLE, ARM, CAPTURE, DONE), RGB565 pixel type, default OUT_W/OUT_H/DECIM constants.
- One sub-module natural: cam_pixel_assembler. Handles byte-phase toggle, byte pairing, and col_in/row_in counters; emits pix_valid/pix_data/col/row.
- Top handles FSM, keep rule, address counter and output register.

Test Plan:
- Nominal: DECIM=1, OUT_W=4, OUT_H=2; 4 lines x 8 bytes, bytes 0x00..; wr_ready=1 -> 8 writes, addr 0..7, first wr_data=0x0001, then 0x0203. done pulses once after vsync rise; busy low after.
- Decimation: DECIM=2, OUT_W=2, OUT_H=2; 4 lines x 4 pixels, pixel = {row,col} -> writes 0x0000, 0x0002, 0x0200, 0x0202 at addr 0..3.
- Arming: start while vsync low mid-frame -> no writes until after next vsync 1->0; start during CAPTURE ignored (busy unchanged, no restart).
- Backpressure: wr_ready=0 for 3 pixel periods -> first pixel held stable, next kept pixels dropped, overflow=1. Addresses of later accepted pixels match position; overflow cleared on next start.
- Odd byte/short frame: 7-byte line -> 3 pixels, last byte discarded. Frame with 1 of 2 lines -> done still pulses, only addr 0..OUT_W-1 written.
- Reset mid-CAPTURE: assert reset for 1 cycle after 3 writes -> wr_valid=0, busy=0, no done pulse; next start captures a fresh frame from addr 0.
